// File: rtl/vending_pkg.sv
// Shared definitions for the vend controller: coin codes and default pricing.
package vending_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_A    = 2'b01,
    COIN_B    = 2'b10,
    COIN_INV  = 2'b11
  } coin_e;

  localparam int unsigned DEFAULT_PRICE      = 15;
  localparam int unsigned DEFAULT_COIN_A_VAL = 5;
  localparam int unsigned DEFAULT_COIN_B_VAL = 10;
  localparam int unsigned DEFAULT_CREDIT_W   = 5;

endpackage

// File: rtl/vending_coin_decode.sv
// Combinational coin decoder: maps the 2-bit coin code to a credit value.
module vending_coin_decode
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W   = DEFAULT_CREDIT_W,
  parameter int unsigned COIN_A_VAL = DEFAULT_COIN_A_VAL,
  parameter int unsigned COIN_B_VAL = DEFAULT_COIN_B_VAL
) (
  input  logic [1:0]          coin,
  output logic [CREDIT_W-1:0] value,
  output logic                valid
);

  // Decode coin code; none and invalid codes carry zero value.
  always_comb begin
    value = '0;
    valid = 1'b0;
    case (coin)
      COIN_A: begin
        value = CREDIT_W'(COIN_A_VAL);
        valid = 1'b1;
      end
      COIN_B: begin
        value = CREDIT_W'(COIN_B_VAL);
        valid = 1'b1;
      end
      default: begin
        value = '0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vending_machine.sv
// Coin-operated vend controller: accumulates credit, pulses dispense and
// reports overpayment on change when credit reaches the price.
module vending_machine
  import vending_pkg::*;
#(
  parameter int unsigned PRICE      = DEFAULT_PRICE,
  parameter int unsigned COIN_A_VAL = DEFAULT_COIN_A_VAL,
  parameter int unsigned COIN_B_VAL = DEFAULT_COIN_B_VAL,
  parameter int unsigned CREDIT_W   = DEFAULT_CREDIT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  output logic                dispense,
  output logic [CREDIT_W-1:0] change
);

  localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W + 1)'(PRICE);

  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] credit_next;
  logic [CREDIT_W-1:0] coin_value;
  logic                coin_valid;
  logic [CREDIT_W-1:0] add_value;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W:0]   excess;
  logic                dispense_next;
  logic [CREDIT_W-1:0] change_next;

  vending_coin_decode #(
    .CREDIT_W   (CREDIT_W),
    .COIN_A_VAL (COIN_A_VAL),
    .COIN_B_VAL (COIN_B_VAL)
  ) u_decode (
    .coin  (coin),
    .value (coin_value),
    .valid (coin_valid)
  );

  // Add the coin to credit; vend and return the excess once the price is met.
  always_comb begin
    credit_next   = credit;
    dispense_next = 1'b0;
    change_next   = '0;
    add_value     = coin_valid ? coin_value : '0;
    sum           = {1'b0, credit} + {1'b0, add_value};
    excess        = sum - PRICE_W;
    if (sum >= PRICE_W) begin
      credit_next   = '0;
      dispense_next = 1'b1;
      change_next   = excess[CREDIT_W-1:0];
    end else begin
      credit_next   = sum[CREDIT_W-1:0];
    end
  end

  // Credit and output registers; asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit   <= '0;
      dispense <= 1'b0;
      change   <= '0;
    end else begin
      credit   <= credit_next;
      dispense <= dispense_next;
      change   <= change_next;
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: table of coin vectors plus
// hand-written reset sequences, checked through an expected-output queue.
module tb_vending_machine;

  localparam int unsigned CW = 5;
  localparam int unsigned NV = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    coin;
  logic          dispense;
  logic [CW-1:0] change;

  always #5 clk = ~clk;

  vending_machine #(
    .PRICE      (15),
    .COIN_A_VAL (5),
    .COIN_B_VAL (10),
    .CREDIT_W   (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .coin     (coin),
    .dispense (dispense),
    .change   (change)
  );

  typedef struct packed {
    logic          d;
    logic [CW-1:0] c;
  } exp_t;

  typedef struct {
    logic [1:0]    coin;
    logic          d;
    logic [CW-1:0] c;
  } vec_t;

  exp_t sb[$];
  vec_t vt[NV];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic expect_out(input logic d, input logic [CW-1:0] c);
    exp_t e;
    e.d = d;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic check(input string name);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL %s: scoreboard empty, got dispense=%b change=%0d", name, dispense, change);
      return;
    end
    e = sb.pop_front();
    if (dispense !== e.d || change !== e.c) begin
      n_miss++;
      $display("FAIL %s: got dispense=%b change=%0d, expected dispense=%b change=%0d",
               name, dispense, change, e.d, e.c);
    end
  endtask

  // Present a coin, let one rising edge sample it, check just after the edge.
  task automatic step(input logic [1:0] c, input logic d, input logic [CW-1:0] ch,
                      input string name);
    coin = c;
    expect_out(d, ch);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    // Credit starts at 0 after reset; comments give credit after each edge.
    vt[0]  = '{2'b00, 1'b0, 5'd0};  // idle
    vt[1]  = '{2'b00, 1'b0, 5'd0};
    vt[2]  = '{2'b00, 1'b0, 5'd0};
    vt[3]  = '{2'b01, 1'b0, 5'd0};  // 5
    vt[4]  = '{2'b10, 1'b1, 5'd0};  // 5+10 vend, 0
    vt[5]  = '{2'b00, 1'b0, 5'd0};
    vt[6]  = '{2'b10, 1'b0, 5'd0};  // 10
    vt[7]  = '{2'b01, 1'b1, 5'd0};  // 10+5 vend, 0
    vt[8]  = '{2'b10, 1'b0, 5'd0};  // 10
    vt[9]  = '{2'b10, 1'b1, 5'd5};  // 10+10 vend, change 5
    vt[10] = '{2'b00, 1'b0, 5'd0};
    vt[11] = '{2'b01, 1'b0, 5'd0};  // 5
    vt[12] = '{2'b11, 1'b0, 5'd0};  // invalid ignored, 5
    vt[13] = '{2'b01, 1'b0, 5'd0};  // 10
    vt[14] = '{2'b11, 1'b0, 5'd0};  // 10
    vt[15] = '{2'b01, 1'b1, 5'd0};  // vend on third 5
    vt[16] = '{2'b10, 1'b0, 5'd0};  // coin in dispense cycle starts fresh: 10
    vt[17] = '{2'b10, 1'b1, 5'd5};  // vend, change 5
    vt[18] = '{2'b01, 1'b0, 5'd0};  // held 01: 5
    vt[19] = '{2'b01, 1'b0, 5'd0};  // 10
    vt[20] = '{2'b01, 1'b1, 5'd0};  // vend
    vt[21] = '{2'b00, 1'b0, 5'd0};

    reset = 1'b0;
    coin  = 2'b00;
    @(posedge clk);
    #1;
    expect_out(1'b0, '0);
    check("reset_state");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < int'(NV); i++) begin
      step(vt[i].coin, vt[i].d, vt[i].c, $sformatf("vec%0d", i));
    end

    // Reset asserted mid-cycle while dispense is high clears outputs at once.
    step(2'b10, 1'b0, 5'd0, "dsp_coin10");
    step(2'b10, 1'b1, 5'd5, "dsp_vend");
    coin = 2'b00;
    #2;
    reset = 1'b0;
    #1;
    expect_out(1'b0, '0);
    check("async_clear_during_vend");
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-accumulation drops the partial credit.
    step(2'b10, 1'b0, 5'd0, "acc_coin10");
    #2;
    reset = 1'b0;
    #1;
    expect_out(1'b0, '0);
    check("async_clear_mid_credit");
    coin = 2'b10;
    @(posedge clk);
    #1;
    expect_out(1'b0, '0);
    check("coin_ignored_in_reset");
    @(negedge clk);
    coin  = 2'b00;
    reset = 1'b1;
    step(2'b01, 1'b0, 5'd0, "post_reset_single_01");
    step(2'b10, 1'b1, 5'd0, "post_reset_complete");
    step(2'b00, 1'b0, 5'd0, "post_reset_idle");

    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
